// File: rtl/mem_copy_engine_pkg.sv
// Shared constants for the block-copy engine: bus width defaults and FSM state
// encodings, kept here so they line up with the MemWrapper port widths.
package mem_copy_engine_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W      = 16;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_READ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies a block of words through a single-port synchronous memory:
// read one word, wait out the read latency, write it, step both pointers.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataw,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LATENCY - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    // The write-data register doubles as the captured-word register.
    logic [DATA_W-1:0]  dataw_q, dataw_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        dataw_d = dataw_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = length;
                    if (length != '0) begin
                        state_d = ST_READ;
                        addr_d  = src_addr;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
                wcnt_d  = WCNT_LAST;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    dataw_d = mem_rdata;
                    addr_d  = dst_q;
                    state_d = ST_WRITE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_WRITE: begin
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                    addr_d  = src_q + ADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            dataw_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            dataw_q <= dataw_d;
        end
    end

    // Strobes decode straight from the state register, so reset clears them at once.
    assign mem_addr  = addr_q;
    assign mem_dataw = dataw_q;
    assign mem_we    = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural single-port memory, a write scoreboard
// filled from a shadow copy of memory, and latency/pulse-count checks per copy.
module tb_mem_copy_engine;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [15:0] mem_addr;
    logic [15:0] mem_dataw;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [15:0] mem    [0:65535];
    logic [15:0] shadow [0:65535];
    wr_t         exp_q  [$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int we_cnt = 0;
    int dn_cnt = 0;

    mem_copy_engine #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_dataw (mem_dataw),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: write on the rising edge, registered read with one cycle of latency.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h1337;
        mem[16'h0002] = 16'hdead;
        mem[16'hffff] = 16'hbeef;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge CLK);
            if (mem_we) mem[mem_addr] <= mem_dataw;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Write monitor: every write strobe must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (done) dn_cnt++;
            if (mem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {16'h0, mem_addr}, 32'hffff_ffff);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
                    check("wr_data", {16'h0, mem_dataw}, {16'h0, e.data});
                    $display("write addr=%h data=%h", mem_addr, mem_dataw);
                end
            end
        end
    end

    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = d;
            e.data = shadow[s];
            shadow[d] = e.data;
            exp_q.push_back(e);
            s = s + 16'd1;
            d = d + 16'd1;
        end
    endtask

    // Leaves the caller at the falling edge just after the start edge; s_cyc is that cycle.
    task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                              output int s_cyc);
        @(negedge CLK);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = l;
        @(negedge CLK);
        start = 1'b0;
        s_cyc = cyc;
        check("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_done(input string name, input int s_cyc, input int l,
                             input int we0, input int dn0);
        bit seen = 0;
        int lat  = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1;
                lat  = cyc - s_cyc + 1;
                break;
            end
            @(negedge CLK);
        end
        check({name, "_done_seen"}, {31'h0, seen}, 32'h1);
        check({name, "_latency"}, lat, 3 * l + 1);
        repeat (3) @(negedge CLK);
        check({name, "_we_cycles"}, we_cnt - we0, l);
        check({name, "_done_pulses"}, dn_cnt - dn0, 1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'h0, busy}, 32'h0);
        $display("copy %s latency=%0d writes=%0d", name, lat, we_cnt - we0);
    endtask

    task automatic run_copy(input string name, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l);
        int sc, we0, dn0;
        we0 = we_cnt;
        dn0 = dn_cnt;
        push_copy(s, d, int'(l));
        start_copy(s, d, l, sc);
        wait_done(name, sc, int'(l), we0, dn0);
    endtask

    initial begin
        int sc, we0, dn0;
        for (int i = 0; i < 65536; i++) shadow[i] = 16'h0000;
        shadow[16'h0000] = 16'h1234;
        shadow[16'h0001] = 16'h1337;
        shadow[16'h0002] = 16'hdead;
        shadow[16'hffff] = 16'hbeef;
        RST_N = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length = '0;

        repeat (3) @(negedge CLK);
        check("rst_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_dataw", {16'h0, mem_dataw}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        run_copy("basic", 16'h0000, 16'h0010, 16'd3);
        check("basic_m10", {16'h0, mem[16'h0010]}, 32'h1234);
        check("basic_m11", {16'h0, mem[16'h0011]}, 32'h1337);
        check("basic_m12", {16'h0, mem[16'h0012]}, 32'hdead);

        run_copy("len0", 16'h0000, 16'h0020, 16'd0);
        check("len0_m20", {16'h0, mem[16'h0020]}, 32'h0);

        run_copy("wrap", 16'hffff, 16'h0030, 16'd2);
        check("wrap_m30", {16'h0, mem[16'h0030]}, 32'hbeef);
        check("wrap_m31", {16'h0, mem[16'h0031]}, 32'h1234);

        // Second start arrives mid-copy and must be dropped.
        we0 = we_cnt;
        dn0 = dn_cnt;
        push_copy(16'h0000, 16'h0040, 3);
        start_copy(16'h0000, 16'h0040, 16'd3, sc);
        repeat (2) @(negedge CLK);
        start    = 1'b1;
        src_addr = 16'h0002;
        dst_addr = 16'h0060;
        length   = 16'd3;
        @(negedge CLK);
        start = 1'b0;
        wait_done("ignore", sc, 3, we0, dn0);
        check("ignore_m60", {16'h0, mem[16'h0060]}, 32'h0);
        check("ignore_m42", {16'h0, mem[16'h0042]}, 32'hdead);

        // Asynchronous reset during the WAIT of the second word.
        we0 = we_cnt;
        dn0 = dn_cnt;
        push_copy(16'h0000, 16'h0070, 1);
        start_copy(16'h0000, 16'h0070, 16'd3, sc);
        repeat (4) @(negedge CLK);
        check("mid_busy", {31'h0, busy}, 32'h1);
        check("mid_addr", {16'h0, mem_addr}, 32'h1);
        #1 RST_N = 1'b0;
        #1;
        check("arst_addr", {16'h0, mem_addr}, 32'h0);
        check("arst_dataw", {16'h0, mem_dataw}, 32'h0);
        check("arst_we", {31'h0, mem_we}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("arst_we_cycles", we_cnt - we0, 1);
        check("arst_done_pulses", dn_cnt - dn0, 0);
        check("arst_sb_empty", exp_q.size(), 0);
        check("arst_idle", {31'h0, busy}, 32'h0);
        check("arst_m70", {16'h0, mem[16'h0070]}, 32'h1234);
        check("arst_m71", {16'h0, mem[16'h0071]}, 32'h0);
        $display("copy reset_abort writes=%0d", we_cnt - we0);

        run_copy("overlap", 16'h0000, 16'h0001, 16'd2);
        check("overlap_m1", {16'h0, mem[16'h0001]}, 32'h1234);
        check("overlap_m2", {16'h0, mem[16'h0002]}, 32'h1234);

        for (int i = 0; i < 128; i++) begin
            if (mem[i] !== shadow[i]) check("final_mem", {16'h0, mem[i]}, {16'h0, shadow[i]});
        end
        check("final_mem_ffff", {16'h0, mem[16'hffff]}, {16'h0, shadow[16'hffff]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Memory-side initiator that drives the MemWrapper single-port interface (write data, address, write enable, read data) to copy a block of 16-bit words from a source range to a destination range. It sits between control logic (start/length/addresses) and MemWrapper, and owns the memory port while busy. It issues one read per word, waits out the synchronous read latency, captures the word, then issues the write.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width
RD_LATENCY, 1, cycles from an address being sampled by MemWrapper until mem_rdata is valid (must be >= 1)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a copy; sampled only in IDLE
src_addr  in  ADDR_W  first source word address, latched when start is accepted
dst_addr  in  ADDR_W  first destination word address, latched when start is accepted
length  in  16  number of words to copy, latched when start is accepted
mem_addr  out  ADDR_W  to MemWrapper addr_in
mem_dataw  out  DATA_W  to MemWrapper dataw_in
mem_we  out  1  to MemWrapper memw; write occurs on the rising edge while high
mem_rdata  in  DATA_W  from MemWrapper mem_out
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse when the copy completes

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; mem_addr=0, mem_dataw=0, mem_we=0, busy=0, done=0; internal counters and latched addresses cleared. Reset mid-copy abandons the copy immediately; no further writes; words already written remain.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: mem_we=0. start=1 latches src/dst/length and sets the remaining count to length. Next state is READ if length!=0, else DONE.
- READ (1 cycle): mem_addr=current src, mem_we=0. -> WAIT.
- WAIT (RD_LATENCY cycles): mem_we=0. On the last WAIT cycle, capture mem_rdata into the data register. -> WRITE.
- WRITE (1 cycle): mem_addr=current dst, mem_dataw=captured word, mem_we=1. At the edge: src+=1, dst+=1, remaining-=1. If the remaining count reaches 0 -> DONE, else -> READ.
- DONE (1 cycle): done=1, busy=1, mem_we=0. -> IDLE.
- Cost: RD_LATENCY+2 cycles per word. With default latency, done is high 3*length+1 cycles after the start edge. For length=0, done is high in the cycle right after the start edge, and there is no memory access.
- mem_we is high only in WRITE. mem_addr and mem_dataw are registered outputs; outside READ and WRITE they hold their last value.
- Address arithmetic wraps modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
- start while busy=1 is ignored, with no queuing. start in the DONE cycle is also ignored.
- Copy is strictly ascending, with no overlap detection. If dst lies in (src, src+length), replicated data is the defined result.

Decomposition:
- Shared package: state encoding constants (IDLE, READ, WAIT, WRITE, DONE) and the ADDR_W/DATA_W defaults, so these match MemWrapper.
- Single module. No sub-module is warranted; the address and count registers stay inline.

Test Plan:
- Preload mem[0]=1234, mem[1]=1337, mem[2]=dead. start with src=0, dst=0x10, length=3 -> mem[0x10..0x12]=1234,1337,dead. done pulses exactly 10 cycles after the start edge. mem_we is high for exactly 3 cycles.
- length=0, src=0, dst=0x20 -> done on the next cycle, mem_we never high, mem[0x20] unchanged.
- src=0xFFFF (=beef), dst=0x0030, length=2 -> mem[0x30]=beef and mem[0x31]=mem[0x0000]=1234, confirming address wrap.
- start with length=3, then a second start with src=2 at cycle 4 -> second start ignored. Only the first copy occurs, and only one done pulse.
- Drive RST_N low during the WAIT state of the 2nd word of a 3-word copy -> outputs go to 0 immediately (asynchronously), only the first destination word is written, and the state is IDLE after release.
- Overlapping copy: src=0, dst=1, length=2 with mem[0]=1234, mem[1]=1337 -> mem[1]=1234, mem[2]=1234.
